// File: rtl/uart_tx_dev.sv
// Bridge-attached 8N1 UART transmitter: a CPU-writable TX FIFO feeding a baud-rate serialiser,
// with STATUS/CTRL/DIV registers and a level interrupt raised when everything has drained.
module uart_tx_dev #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    parameter int DIV_RST    = 433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] D,
    input  logic [1:0]  A,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] Dout,
    output logic        tx,
    output logic        INT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_DIV    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Registers
    logic             r_en;
    logic             r_ie;
    logic             r_ovf;
    logic             r_int;
    logic [DIV_W-1:0] r_div;

    // Serialiser
    state_t           r_state;
    logic [DIV_W-1:0] r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;

    // Combinational
    state_t           w_state_nx;
    logic [DIV_W-1:0] w_baud_nx;
    logic [2:0]       w_bit_idx_nx;
    logic [7:0]       w_shift_nx;
    logic             w_tx_nx;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_busy;
    logic             w_push_req;
    logic             w_push;
    logic             w_ovf_evt;
    logic             w_ctrl_wr;
    logic             w_div_wr;
    logic [DIV_W-1:0] w_div_nx;
    logic             w_unused_d;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_busy     = (r_state != S_IDLE);
    assign w_push_req = we && (A == A_TXDATA) && be[0];
    // A full FIFO still accepts a byte when the serialiser frees a slot on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;
    assign w_ctrl_wr  = we && (A == A_CTRL) && be[0];
    assign w_div_wr   = we && (A == A_DIV);
    assign w_unused_d = ^D;

    // NOTE: storage has no reset; only pointers and count define FIFO contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= D[7:0];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_div_nx = r_div;
        if (w_div_wr) begin
            for (int i = 0; i < DIV_W; i++) begin
                if (be[i/8]) begin
                    w_div_nx[i] = D[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_ovf <= 1'b0;
            r_div <= DIV_INIT;
            r_int <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_en <= D[0];
                r_ie <= D[1];
            end
            // An overflow on the same edge as a clear leaves the flag set.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_ctrl_wr && D[2]) begin
                r_ovf <= 1'b0;
            end
            r_div <= w_div_nx;
            r_int <= r_ie && w_empty && (r_state == S_IDLE);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx   = r_state;
        w_baud_nx    = r_baud;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        w_pop        = 1'b0;
        w_tx_nx      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_en && !w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rd_ptr];
                    w_baud_nx  = r_div;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (r_baud == '0) begin
                    w_state_nx   = S_DATA;
                    w_bit_idx_nx = '0;
                    w_baud_nx    = r_div;
                end else begin
                    w_baud_nx = r_baud - DIV_ONE;
                end
            end
            S_DATA: begin
                if (r_baud == '0) begin
                    w_baud_nx = r_div;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nx = r_baud - DIV_ONE;
                end
            end
            S_STOP: begin
                if (r_baud == '0) begin
                    // Chain straight into the next frame when data is waiting.
                    if (r_en && !w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = r_mem[r_rd_ptr];
                        w_baud_nx  = r_div;
                        w_state_nx = S_START;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_baud_nx = r_baud - DIV_ONE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_state_nx == S_START) begin
            w_tx_nx = 1'b0;
        end else if (w_state_nx == S_DATA) begin
            w_tx_nx = w_shift_nx[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_baud    <= w_baud_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_shift   <= w_shift_nx;
            r_tx      <= w_tx_nx;
        end
    end

    always_comb begin
        Dout = '0;
        case (A)
            A_STATUS: Dout = {16'b0, 8'(r_count), 4'b0, r_ovf, w_busy, w_empty, w_full};
            A_CTRL:   Dout = {30'b0, r_ie, r_en};
            A_DIV:    Dout = 32'(r_div);
            default:  Dout = '0;
        endcase
    end

    assign tx  = r_tx;
    assign INT = r_int;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomised bench for uart_tx_dev: a frame-level reference model (FIFO queue plus elapsed-time
// per frame) is compared against tx, INT and Dout every cycle, with directed literal checks.
module tb_uart_tx_dev;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] D;
    logic [1:0]  A;
    logic [3:0]  be;
    logic        we;
    logic [31:0] Dout;
    logic        tx;
    logic        INT;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_busy;
    bit          m_en;
    bit          m_ie;
    bit          m_ovf;
    bit          m_int;
    int          m_elapsed;
    logic [15:0] m_fdiv;
    logic [15:0] m_div;
    logic [7:0]  m_byte;

    uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RST(433)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .A     (A),
        .be    (be),
        .we    (we),
        .Dout  (Dout),
        .tx    (tx),
        .INT   (INT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy    = 0;
        m_en      = 0;
        m_ie      = 0;
        m_ovf     = 0;
        m_int     = 0;
        m_elapsed = 0;
        m_fdiv    = 16'd0;
        m_div     = 16'd433;
        m_byte    = 8'h00;
    endtask

    // One clock edge of the transmitter, described frame by frame.
    task automatic model_edge(input logic we_i, input logic [1:0] a_i, input logic [31:0] d_i,
                              input logic [3:0] be_i);
        bit frame_end;
        bit pop;
        bit push_req;
        bit full;
        bit next_int;
        next_int  = m_ie && (m_q.size() == 0) && !m_busy;
        frame_end = m_busy && (m_elapsed == 10 * (int'(m_fdiv) + 1) - 1);
        pop       = m_en && (m_q.size() > 0) && (!m_busy || frame_end);
        push_req  = we_i && (a_i == 2'd0) && be_i[0];
        full      = (m_q.size() == DEPTH);
        if (pop) begin
            m_byte    = m_q.pop_front();
            m_busy    = 1;
            m_elapsed = 0;
            m_fdiv    = m_div;
        end else if (m_busy) begin
            if (frame_end) m_busy = 0;
            else m_elapsed++;
        end
        if (push_req && (!full || pop)) m_q.push_back(d_i[7:0]);
        if (push_req && full && !pop) m_ovf = 1;
        else if (we_i && a_i == 2'd2 && be_i[0] && d_i[2]) m_ovf = 0;
        if (we_i && a_i == 2'd2 && be_i[0]) begin
            m_en = d_i[0];
            m_ie = d_i[1];
        end
        if (we_i && a_i == 2'd3) begin
            if (be_i[0]) m_div[7:0] = d_i[7:0];
            if (be_i[1]) m_div[15:8] = d_i[15:8];
        end
        m_int = next_int;
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_elapsed / (int'(m_fdiv) + 1);
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_dout(input logic [1:0] a_i);
        int sz;
        sz = m_q.size();
        case (a_i)
            2'd1:    return {16'b0, 8'(sz), 4'b0, m_ovf, m_busy, sz == 0, sz == DEPTH};
            2'd2:    return {30'b0, m_ie, m_en};
            2'd3:    return {16'b0, m_div};
            default: return 32'h0;
        endcase
    endfunction

    task automatic compare();
        check("tx", {31'b0, tx}, {31'b0, exp_tx()});
        check("int", {31'b0, INT}, {31'b0, m_int});
        check("dout", Dout, exp_dout(A));
    endtask

    task automatic step(input logic we_i, input logic [1:0] a_i, input logic [31:0] d_i,
                        input logic [3:0] be_i);
        we = we_i;
        A  = a_i;
        D  = d_i;
        be = be_i;
        @(posedge clk);
        model_edge(we_i, a_i, d_i, be_i);
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input logic [1:0] a_i, input logic [31:0] d_i, input logic [3:0] be_i);
        step(1'b1, a_i, d_i, be_i);
    endtask

    task automatic rd(input logic [1:0] a_i);
        step(1'b0, a_i, 32'h0, 4'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 5000) begin
            rd(2'd1);
            n++;
        end
        check("drain_busy", {31'b0, Dout[2]}, 32'h0);
    endtask

    initial begin
        int first_idle;
        int busy_cnt;
        int first_int;
        int n;
        logic [9:0]  pat;
        logic [31:0] rnd;
        logic [3:0]  rbe;

        rst_n = 1'b0;
        we    = 1'b0;
        A     = 2'd0;
        D     = 32'h0;
        be    = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        // Reset values
        rd(2'd1);
        check("rst_status", Dout, 32'h0000_0002);
        rd(2'd2);
        check("rst_ctrl", Dout, 32'h0);
        rd(2'd3);
        check("rst_div", Dout, 32'd433);
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_int", {31'b0, INT}, 32'h0);

        // Single frame of 8'hA5 at DIV=3
        wr(2'd3, 32'd3, 4'b0011);
        wr(2'd2, 32'd1, 4'b0001);
        wr(2'd0, 32'h0000_00A5, 4'b0001);
        pat      = 10'b1101001010;
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            rd(2'd1);
            if (Dout[2]) busy_cnt++;
            if (i < 40 && (i % 4) == 1) check("a5_bit", {31'b0, tx}, {31'b0, pat[i/4]});
        end
        check("a5_busy_cycles", busy_cnt, 40);

        // Overflow, clear, then eight back-to-back frames
        wr(2'd2, 32'd0, 4'b0001);
        for (int i = 0; i < 9; i++) wr(2'd0, $urandom(), 4'b0001);
        rd(2'd1);
        check("ovf_status", Dout, 32'h0000_0809);
        wr(2'd2, 32'd4, 4'b0001);
        rd(2'd1);
        check("ovf_clr_status", Dout, 32'h0000_0801);
        wr(2'd2, 32'd1, 4'b0001);
        first_idle = -1;
        busy_cnt   = 0;
        for (int i = 0; i < 330; i++) begin
            rd(2'd1);
            if (Dout[2]) busy_cnt++;
            else if (first_idle < 0) first_idle = i;
        end
        check("b2b_busy_cycles", busy_cnt, 320);
        check("b2b_first_idle", first_idle, 320);

        // Interrupt timing at DIV=0
        wr(2'd2, 32'd0, 4'b0001);
        wr(2'd3, 32'd0, 4'b0011);
        wr(2'd0, 32'h0000_0011, 4'b0001);
        wr(2'd0, 32'h0000_0022, 4'b0001);
        wr(2'd2, 32'd3, 4'b0001);
        first_int = -1;
        for (int i = 0; i < 30; i++) begin
            rd(2'd1);
            if (INT && first_int < 0) first_int = i;
        end
        check("int_rise_idx", first_int, 21);
        wr(2'd0, 32'h0000_0033, 4'b0001);
        check("int_push_edge", {31'b0, INT}, 32'h1);
        rd(2'd1);
        check("int_drop", {31'b0, INT}, 32'h0);

        // Push into a full FIFO on the edge the serialiser pops
        wr(2'd2, 32'd0, 4'b0001);
        drain();
        wr(2'd3, 32'd3, 4'b0011);
        for (int i = 0; i < 8; i++) wr(2'd0, $urandom(), 4'b0001);
        rd(2'd1);
        check("full_status", Dout, 32'h0000_0801);
        wr(2'd2, 32'd1, 4'b0001);
        wr(2'd0, 32'h0000_005A, 4'b0001);
        rd(2'd1);
        check("push_on_pop_status", Dout, 32'h0000_0805);

        // Randomised traffic, DIV changed only while the serialiser is idle
        for (int seg = 0; seg < 6; seg++) begin
            wr(2'd2, 32'd0, 4'b0001);
            drain();
            rnd = $urandom();
            wr(2'd3, {rnd[31:16], 16'($urandom_range(0, 5))}, 4'hF);
            for (int i = 0; i < 400; i++) begin
                n   = $urandom_range(0, 9);
                rnd = $urandom();
                rbe = 4'($urandom_range(0, 15));
                if (n <= 2) wr(2'd0, rnd, rbe | 4'b0001);
                else if (n == 3) wr(2'd0, rnd, rbe);
                else if (n == 4) wr(2'd2, {29'b0, rnd[2:0]}, rbe | 4'($urandom_range(0, 1)));
                else if (n == 5) wr(2'd1, rnd, 4'hF);
                else step(1'b0, 2'($urandom_range(0, 3)), rnd, 4'hF);
            end
        end

        // Empty everything, then reset in the middle of a data bit
        wr(2'd2, 32'd5, 4'b0001);
        n = 0;
        while ((m_q.size() > 0 || m_busy) && n < 3000) begin
            rd(2'd1);
            n++;
        end
        check("flush_status", Dout, 32'h0000_0002);
        wr(2'd3, 32'd7, 4'b0011);
        wr(2'd0, 32'h0000_0000, 4'b0001);
        n = 0;
        while (!(m_busy && m_elapsed == 19) && n < 200) begin
            rd(2'd1);
            n++;
        end
        check("pre_reset_tx", {31'b0, tx}, 32'h0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_tx", {31'b0, tx}, 32'h1);
        check("async_rst_int", {31'b0, INT}, 32'h0);
        check("async_rst_status", Dout, 32'h0000_0002);
        A = 2'd2;
        #1;
        check("async_rst_ctrl", Dout, 32'h0);
        A = 2'd3;
        #1;
        check("async_rst_div", Dout, 32'd433);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        for (int i = 0; i < 20; i++) rd(2'd1);
        check("post_rst_status", Dout, 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
